issuels_unit: RTL
=================

ISSUELS_UNIT -- requirements
Module: issuels_unit

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 clk  in  1  single clock; all state changes on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 issuels_opcode  in  1  0 = LW, 1 = SW.
REQ-005 issuels_rttag  in  6  LW destination tag; unused for SW.
REQ-006 issuels_rtdata  in  32  SW store data; unused for LW.
REQ-007 issuels_rsdata  in  32  base address operand.
REQ-008 issuels_imm  in  32  sign-extended offset.
REQ-009 issuels_ready  in  1  queue head is valid and operand-ready.
REQ-010 issuels_done  out  1  head accepted this cycle; the queue dequeues at the next edge.
REQ-011 dmem_en  out  1  memory request active.
REQ-012 dmem_we  out  1  1 = write, 0 = read; meaningful only while dmem_en is high.
REQ-013 dmem_addr  out  32  byte address.
REQ-014 dmem_wdata  out  32  write data.
REQ-015 dmem_rdata  in  32  read data, sampled only when dmem_valid is high.
REQ-016 dmem_valid  in  1  request completion, latency 1..N cycles.
REQ-017 lscdb_req  out  1  LW result requests the CDB.
REQ-018 lscdb_grant  in  1  CDB arbiter grant for this cycle.
REQ-019 lscdb_tag  out  6  result tag.
REQ-020 lscdb_data  out  32  result data.
REQ-021 busy  out  1  high when state is not IDLE.

Function
REQ-022 FSM states: IDLE, MEM, CDB; exactly one state at a time; reset state is IDLE.
REQ-023 issuels_done = issuels_ready & (state==IDLE) & ~reset, combinational; it is never high in MEM or CDB.
REQ-024 On accept (issuels_done high at an edge), register the operation:
  - op_addr = (issuels_rsdata + issuels_imm) mod 2^32; carry discarded; address bits [1:0] passed unchecked.
  - Also register issuels_opcode, issuels_rttag and issuels_rtdata.
  - Next state is MEM.
REQ-025 In MEM, dmem_en=1 with registered values: dmem_we=opcode, dmem_addr=op_addr, dmem_wdata=rtdata.
  - All four are held stable until dmem_valid is seen.
REQ-026 dmem_valid in MEM with SW: next state IDLE; dmem_en low from the next cycle.
  - No CDB activity for SW.
REQ-027 dmem_valid in MEM with LW: capture dmem_rdata into the result register; next state CDB.
REQ-028 dmem_valid in MEM in the same cycle as entry to MEM is impossible.
  - The earliest valid is the first cycle in MEM: minimum LW latency is accept edge + 1 (MEM) + 1 (CDB).
REQ-029 In CDB, lscdb_req=1, lscdb_tag=rttag, lscdb_data=captured rdata.
  - All three are held stable until lscdb_grant is high.
  - On grant, next state is IDLE.
REQ-030 lscdb_req is 0 outside CDB; lscdb_tag and lscdb_data hold their last value outside CDB.
REQ-031 dmem_valid outside MEM and lscdb_grant outside CDB are ignored, with no state change.
REQ-032 Strict in-order, one operation in flight; the next accept is possible in the cycle after returning to IDLE.
  - Minimum SW throughput: 1 per 2 cycles.
REQ-033 Issue inputs are ignored outside IDLE; the queue holds its head because issuels_done is low.
REQ-034 busy = (state != IDLE).

Reset
REQ-035 While reset is high at an edge:
  - state <= IDLE.
  - All registered outputs and registers <= 0 (dmem_addr, dmem_wdata, dmem_we, op/result registers, lscdb_tag, lscdb_data).
REQ-036 Combinational outputs are 0 while in IDLE after reset: dmem_en=0, lscdb_req=0, busy=0, and issuels_done=0 during reset.
REQ-037 Reset mid-operation (MEM or CDB) abandons the operation.
  - No dmem_en or lscdb_req in the cycle after the reset edge.
  - A late dmem_valid or lscdb_grant after reset is ignored.

Verification
REQ-038 LW: rsdata=0x100, imm=0xFFFFFFFC, rttag=0x2A, ready=1 at cycle 0 -> done=1 in cycle 0.
  - Cycle 1: dmem_en=1, we=0, addr=0xFC.
  - dmem_valid with rdata=0xDEADBEEF in cycle 1 -> cycle 2: lscdb_req=1, tag=0x2A, data=0xDEADBEEF.
  - grant in cycle 2 -> IDLE and busy=0 in cycle 3.
REQ-039 SW with 3-cycle memory latency: rsdata=0xFFFFFFF0, imm=0x14, rtdata=0x12345678.
  - dmem_addr=0x4 (wrap) and wdata held for 3 cycles.
  - No lscdb_req at any point; done=0 throughout.
REQ-040 Back-to-back: ready held high with SW then LW -> done pulses only in IDLE cycles, 2 cycles apart minimum.
  - Operations are executed in order.
REQ-041 CDB backpressure: grant withheld 4 cycles -> lscdb_req, tag and data stable for all 4 cycles.
  - done=0 throughout; completion on the first grant.
REQ-042 Reset asserted in MEM, then dmem_valid the next cycle -> state IDLE, all outputs 0, no lscdb_req.
  - A subsequent LW completes normally.
REQ-043 Stray dmem_valid and lscdb_grant pulses in IDLE -> no state change and no outputs asserted.

Source files
------------

// File: rtl/issuels_unit.sv
// issuels_unit -- load/store issue unit with one operation in flight.
//
// Accepts a LW/SW from the head of the load/store issue queue while idle,
// computes the effective address, drives a single data-memory request and
// (for LW) delivers the loaded word on the common data bus.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   issuels_*         issue-queue head: opcode (0=LW,1=SW), rttag, rtdata,
//                     rsdata (base), imm (offset), ready; done = accepted
//   dmem_*            memory request (en/we/addr/wdata) and response
//                     (rdata/valid, latency >= 1 cycle)
//   lscdb_*           CDB request (req/tag/data) and arbiter grant
//   busy              operation in flight (state != IDLE)
module issuels_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        issuels_opcode,
    input  logic [5:0]  issuels_rttag,
    input  logic [31:0] issuels_rtdata,
    input  logic [31:0] issuels_rsdata,
    input  logic [31:0] issuels_imm,
    input  logic        issuels_ready,
    output logic        issuels_done,
    output logic        dmem_en,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_valid,
    output logic        lscdb_req,
    input  logic        lscdb_grant,
    output logic [5:0]  lscdb_tag,
    output logic [31:0] lscdb_data,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_CDB} state_t;

    state_t     state;
    logic [5:0] op_tag;

    // Accept only from IDLE and never while reset is being applied.
    assign issuels_done = issuels_ready & (state == S_IDLE) & ~reset;
    assign dmem_en      = (state == S_MEM);
    assign lscdb_req    = (state == S_CDB);
    assign busy         = (state != S_IDLE);

    // The memory request fields double as the operation registers, so they
    // are naturally stable for the whole MEM phase. The CDB tag/data are
    // only loaded on the MEM->CDB transition so they hold their last value
    // everywhere else.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            op_tag     <= '0;
            lscdb_tag  <= '0;
            lscdb_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (issuels_ready) begin
                        dmem_we    <= issuels_opcode;
                        dmem_addr  <= issuels_rsdata + issuels_imm;
                        dmem_wdata <= issuels_rtdata;
                        op_tag     <= issuels_rttag;
                        state      <= S_MEM;
                    end
                end
                S_MEM: begin
                    if (dmem_valid) begin
                        if (dmem_we) begin
                            state <= S_IDLE;
                        end else begin
                            lscdb_tag  <= op_tag;
                            lscdb_data <= dmem_rdata;
                            state      <= S_CDB;
                        end
                    end
                end
                S_CDB: begin
                    if (lscdb_grant) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
